// File: rtl/t08_wb_pkg.sv
// Shared types and defaults for the t08 Wishbone classic master.
package t08_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT  = 255;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/t08_wb_timer.sv
// Saturating cycle counter that flags when the current cycle is the last one allowed.
module t08_wb_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W:0]   next_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry looks one step ahead so the abort lands on the edge where the count reaches the limit.
  assign next_count = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign expired    = enable && (next_count >= {1'b0, limit});

endmodule

// File: rtl/t08_wb_master.sv
// Wishbone classic single-transfer master driven by level read/write requests.
module t08_wb_master
  import t08_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  sel_in,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] dat_i
);

  wb_state_e state;
  logic      accept;
  logic      in_bus;
  logic      expired;

  assign accept = (state == IDLE) && (rd_req || wr_req);
  assign in_bus = (state == READ) || (state == WRITE);

  t08_wb_timer #(.W(32)) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (accept),
    .enable  (in_bus),
    .limit   (32'(TIMEOUT)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      rdata_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      sel_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (rd_req || wr_req) begin
            state <= wr_req ? WRITE : READ;
            we_o  <= wr_req;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            busy  <= 1'b1;
            adr_o <= addr_in;
            dat_o <= wdata_in;
            sel_o <= sel_in;
          end
        end
        READ, WRITE: begin
          // A bus error beats a simultaneous ack, but an ack beats the timer on its final cycle.
          if (err_i || (expired && !ack_i)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            if (state == READ) begin
              rdata_out <= ERR_DATA;
            end
          end else if (ack_i) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            if (state == READ) begin
              rdata_out <= dat_i;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t08_wb_master.sv
// Directed plus randomized transactions against a transaction-level model of the master.
module tb_t08_wb_master;

  localparam int TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk;
  logic        nrst;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [3:0]  sel_in;
  logic [31:0] rdata_out;
  logic        done;
  logic        busy;
  logic        err;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic        err_i;
  logic [31:0] dat_i;

  int checks = 0;
  int errors = 0;

  // Slave behaviour for the current transaction: mode 0 ack, 1 err, 2 silent, 3 ack+err.
  int          slv_waits = 0;
  int          slv_mode  = 2;
  logic [31:0] slv_data  = '0;
  bit          noise_en  = 1'b0;
  int          slv_cnt   = 0;

  logic [31:0] model_rdata = '0;

  t08_wb_master #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .sel_in    (sel_in),
    .rdata_out (rdata_out),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .ack_i     (ack_i),
    .err_i     (err_i),
    .dat_i     (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The slave updates its responses at the falling edge, counting STB cycles.
  always @(negedge clk) begin
    if (stb_o) begin
      slv_cnt = slv_cnt + 1;
      ack_i = (slv_mode == 0 || slv_mode == 3) && (slv_cnt == slv_waits + 1);
      err_i = (slv_mode == 1 || slv_mode == 3) && (slv_cnt == slv_waits + 1);
      dat_i = slv_data;
    end else begin
      slv_cnt = 0;
      ack_i = noise_en && ($urandom_range(0, 1) == 1);
      err_i = noise_en && ($urandom_range(0, 1) == 1);
      dat_i = noise_en ? $urandom : slv_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cyc"}, 32'(cyc_o), 32'd0);
    checkOutput({tag, "_stb"}, 32'(stb_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_rdata"}, rdata_out, model_rdata);
  endtask

  // One complete transaction, starting and ending #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input string tag, input bit is_wr, input bit both,
                               input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                               input int waits, input int mode, input bit hold);
    int  exp_stb;
    bit  exp_err;
    int  stb_cnt;
    int  cycle;
    bit  got_done;
    if (mode != 2 && waits + 1 <= TMO) begin
      exp_stb = waits + 1;
      exp_err = (mode != 0);
    end else begin
      exp_stb = TMO;
      exp_err = 1'b1;
    end
    slv_waits = waits;
    slv_mode  = mode;
    slv_data  = $urandom;
    addr_in   = a;
    wdata_in  = wd;
    sel_in    = s;
    wr_req    = is_wr;
    rd_req    = !is_wr || both;
    @(posedge clk); #1;
    if (!hold) begin
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      addr_in  = $urandom;
      wdata_in = $urandom;
      sel_in   = 4'($urandom);
    end
    stb_cnt  = 0;
    cycle    = 1;
    got_done = 1'b0;
    while (!got_done && cycle < 64) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_cyc"}, 32'(cyc_o), 32'd1);
        checkOutput({tag, "_stb"}, 32'(stb_o), 32'd1);
        checkOutput({tag, "_we"}, 32'(we_o), 32'(is_wr));
        checkOutput({tag, "_adr"}, adr_o, a);
        checkOutput({tag, "_dat"}, dat_o, wd);
        checkOutput({tag, "_sel"}, 32'(sel_o), 32'(s));
        stb_cnt++;
        @(posedge clk); #1;
        cycle++;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(got_done), 32'd1);
    checkOutput({tag, "_stb_cycles"}, 32'(stb_cnt), 32'(exp_stb));
    checkOutput({tag, "_done_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_cyc"}, 32'(cyc_o), 32'd0);
    checkOutput({tag, "_done_stb"}, 32'(stb_o), 32'd0);
    checkOutput({tag, "_done_we"}, 32'(we_o), 32'd0);
    if (!is_wr) model_rdata = exp_err ? ERRD : slv_data;
    checkOutput({tag, "_rdata"}, rdata_out, model_rdata);
    @(posedge clk); #1;
    checkIdle({tag, "_after"});
  endtask

  initial begin
    nrst     = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr_in  = '0;
    wdata_in = '0;
    sel_in   = '0;
    ack_i    = 1'b0;
    err_i    = 1'b0;
    dat_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    checkOutput("reset_we", 32'(we_o), 32'd0);
    checkOutput("reset_adr", adr_o, 32'd0);
    checkOutput("reset_dat", dat_o, 32'd0);
    checkOutput("reset_sel", 32'(sel_o), 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("zero_wait_read", 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 1'b0);
    applyStimulus("wait3_write", 1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 4'b0011, 3, 0, 1'b0);
    applyStimulus("both_req", 1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_F00D, 4'b1100, 1, 0, 1'b0);
    applyStimulus("timeout_read", 1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 2, 1'b0);
    applyStimulus("bus_err_read", 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1, 1, 1'b0);
    applyStimulus("ack_err_write", 1'b1, 1'b0, 32'h0000_0600, 32'h1111_2222, 4'h1, 0, 3, 1'b0);
    applyStimulus("good_read", 1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'hF, 2, 0, 1'b0);

    // Reset in the middle of a write wait state.
    slv_mode = 2;
    addr_in  = 32'h0000_0800;
    wdata_in = 32'h5555_AAAA;
    sel_in   = 4'hF;
    wr_req   = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_stb_before", 32'(stb_o), 32'd1);
    #2 nrst = 1'b0;
    #1;
    model_rdata = '0;
    checkIdle("rst_mid");
    checkOutput("rst_mid_we", 32'(we_o), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rst_mid_no_done", 32'(done), 32'd0);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
    applyStimulus("post_reset_read", 1'b0, 1'b0, 32'h0000_0900, 32'h0, 4'hF, 0, 0, 1'b0);

    applyStimulus("held_read_1", 1'b0, 1'b0, 32'h0000_0A00, 32'h0, 4'hF, 0, 0, 1'b1);
    applyStimulus("held_read_2", 1'b0, 1'b0, 32'h0000_0B00, 32'h0, 4'hF, 1, 0, 1'b0);

    noise_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 4'($urandom), $urandom_range(0, 5),
                    $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        checkIdle("random_gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
